mem_loader: RTL and testbench

MEM_LOADER -- requirements
Module: mem_loader

---
 rtl/mem_loader_pkg.sv | 20 ++
 rtl/mem_loader.sv | 185 ++++++++++++++++++
 tb/tb_mem_loader.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_loader_pkg.sv
// Shared definitions for the block loader: default widths and the FSM state encoding.
// The SUM state only exists when MEM_LOADER_SUM_EN is defined.
package mem_loader_pkg;

    localparam int DEF_ADDR_W = 7;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_W  = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WRITE = 3'd2,
        ST_FIN   = 3'd3
`ifdef MEM_LOADER_SUM_EN
        ,
        ST_SUM   = 3'd4
`endif
    } state_t;

endpackage

// File: rtl/mem_loader.sv
// Block loader: copies count words from data memory into consecutive register-file slots.
// Define MEM_LOADER_SUM_EN to add the sum_reg port and a final SUM state writing the word total.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_W  = DEF_REG_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [REG_W-1:0]  count,
    input  logic [REG_W-1:0]  dest_reg,
`ifdef MEM_LOADER_SUM_EN
    input  logic [REG_W-1:0]  sum_reg,
`endif
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              reg_write,
    output logic [REG_W-1:0]  reg_waddr,
    output logic [DATA_W-1:0] reg_wdata
);

    // dest_reg + count exceeding this span means the last target register would wrap.
    localparam logic [REG_W:0] REG_SPAN = {1'b1, {REG_W{1'b0}}};

    state_t             state_r;
    logic [ADDR_W-1:0]  base_r;
    logic [REG_W-1:0]   count_r;
    logic [REG_W-1:0]   dest_r;
    logic [REG_W-1:0]   idx_r;
`ifdef MEM_LOADER_SUM_EN
    logic [DATA_W-1:0]  sum_r;
    logic [REG_W-1:0]   sum_reg_r;
`endif

    logic [REG_W-1:0]   idx_next_s;
    logic [REG_W-1:0]   wr_addr_s;
    logic [ADDR_W-1:0]  rd_addr_s;
    logic               reject_s;

    // Address arithmetic and request screening.
    always_comb begin
        idx_next_s = idx_r + {{(REG_W-1){1'b0}}, 1'b1};
        wr_addr_s  = dest_r + idx_r;
        rd_addr_s  = base_r + ADDR_W'(idx_next_s);
        if (count != {REG_W{1'b0}}) begin
            reject_s = ({1'b0, dest_reg} + {1'b0, count}) > REG_SPAN;
        end else begin
            reject_s = 1'b0;
        end
    end

    // Write data follows memory read data in WRITE, and the accumulator in SUM.
    always_comb begin
        reg_wdata = {DATA_W{1'b0}};
        case (state_r)
            ST_WRITE: reg_wdata = mem_rdata;
`ifdef MEM_LOADER_SUM_EN
            ST_SUM:   reg_wdata = sum_r;
`endif
            default:  reg_wdata = {DATA_W{1'b0}};
        endcase
    end

    // Loader FSM with registered control outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            base_r    <= {ADDR_W{1'b0}};
            count_r   <= {REG_W{1'b0}};
            dest_r    <= {REG_W{1'b0}};
            idx_r     <= {REG_W{1'b0}};
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            mem_read  <= 1'b0;
            mem_addr  <= {ADDR_W{1'b0}};
            reg_write <= 1'b0;
            reg_waddr <= {REG_W{1'b0}};
`ifdef MEM_LOADER_SUM_EN
            sum_r     <= {DATA_W{1'b0}};
            sum_reg_r <= {REG_W{1'b0}};
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        base_r  <= base_addr;
                        count_r <= count;
                        dest_r  <= dest_reg;
                        idx_r   <= {REG_W{1'b0}};
`ifdef MEM_LOADER_SUM_EN
                        sum_r     <= {DATA_W{1'b0}};
                        sum_reg_r <= sum_reg;
`endif
                        if (reject_s) begin
                            state_r <= ST_FIN;
                            done    <= 1'b1;
                            err     <= 1'b1;
                        end else if (count == {REG_W{1'b0}}) begin
`ifdef MEM_LOADER_SUM_EN
                            state_r   <= ST_SUM;
                            busy      <= 1'b1;
                            reg_write <= (sum_reg != {REG_W{1'b0}});
                            reg_waddr <= sum_reg;
`else
                            state_r <= ST_FIN;
                            done    <= 1'b1;
`endif
                        end else begin
                            state_r  <= ST_READ;
                            busy     <= 1'b1;
                            mem_read <= 1'b1;
                            mem_addr <= base_addr;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    state_r   <= ST_WRITE;
                    mem_read  <= 1'b0;
                    mem_addr  <= {ADDR_W{1'b0}};
                    reg_write <= (wr_addr_s != {REG_W{1'b0}});
                    reg_waddr <= wr_addr_s;
                end
                ST_WRITE: begin
                    reg_write <= 1'b0;
                    reg_waddr <= {REG_W{1'b0}};
                    idx_r     <= idx_next_s;
`ifdef MEM_LOADER_SUM_EN
                    sum_r     <= sum_r + mem_rdata;
`endif
                    if (idx_next_s < count_r) begin
                        state_r  <= ST_READ;
                        mem_read <= 1'b1;
                        mem_addr <= rd_addr_s;
                    end else begin
`ifdef MEM_LOADER_SUM_EN
                        state_r   <= ST_SUM;
                        reg_write <= (sum_reg_r != {REG_W{1'b0}});
                        reg_waddr <= sum_reg_r;
`else
                        state_r <= ST_FIN;
                        done    <= 1'b1;
                        busy    <= 1'b0;
`endif
                    end
                end
`ifdef MEM_LOADER_SUM_EN
                ST_SUM: begin
                    state_r   <= ST_FIN;
                    reg_write <= 1'b0;
                    reg_waddr <= {REG_W{1'b0}};
                    done      <= 1'b1;
                    busy      <= 1'b0;
                end
`endif
                ST_FIN: begin
                    state_r <= ST_IDLE;
                    done    <= 1'b0;
                    err     <= 1'b0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    err       <= 1'b0;
                    mem_read  <= 1'b0;
                    mem_addr  <= {ADDR_W{1'b0}};
                    reg_write <= 1'b0;
                    reg_waddr <= {REG_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: table of load requests plus hand-written corner sequences.
// Builds with or without MEM_LOADER_SUM_EN; a scoreboard queue checks every register write.
module tb_mem_loader;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
`ifdef MEM_LOADER_SUM_EN
    localparam int SUM_EXTRA = 1;
`else
    localparam int SUM_EXTRA = 0;
`endif

    typedef logic [REG_W+DATA_W-1:0] sb_t;
    typedef struct {
        logic [ADDR_W-1:0] base;
        logic [REG_W-1:0]  cnt;
        logic [REG_W-1:0]  dest;
        int                lat;
        logic              err;
        int                reads;
    } vec_t;

    logic              clock;
    logic              reset_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [REG_W-1:0]  count;
    logic [REG_W-1:0]  dest_reg;
`ifdef MEM_LOADER_SUM_EN
    logic [REG_W-1:0]  sum_reg;
`endif
    logic              busy, done, err, mem_read, reg_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [REG_W-1:0]  reg_waddr;
    logic [DATA_W-1:0] reg_wdata;

    logic [DATA_W-1:0] mem [128];
    logic [DATA_W-1:0] rf  [32];
    sb_t               sb_q [$];
    logic [ADDR_W-1:0] addr_q [$];
    int                read_cnt = 0;
    int                done_cnt = 0;
    int                pass_cnt = 0;
    int                total_cnt = 0;

    mem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .REG_W(REG_W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .dest_reg  (dest_reg),
`ifdef MEM_LOADER_SUM_EN
        .sum_reg   (sum_reg),
`endif
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem_read  (mem_read),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .reg_write (reg_write),
        .reg_waddr (reg_waddr),
        .reg_wdata (reg_wdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else pass_cnt++;
    endtask

    // Synchronous memory and register-file models.
    always @(posedge clock) begin
        if (mem_read) mem_rdata <= mem[mem_addr];
        if (reg_write) rf[reg_waddr] <= reg_wdata;
    end

    // Bus monitor and write scoreboard, sampled mid-cycle.
    always @(negedge clock) begin
        sb_t e;
        check("rd_wr_excl", {63'd0, mem_read & reg_write}, 64'd0);
        if (reset_n && !mem_read) check("addr_idle", {57'd0, mem_addr}, 64'd0);
        if (mem_read) begin
            read_cnt++;
            addr_q.push_back(mem_addr);
        end
        if (done) done_cnt++;
        if (reg_write) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_write", {59'd0, reg_waddr}, 64'hFFFF);
            end else begin
                e = sb_q.pop_front();
                check("sb_waddr", {59'd0, reg_waddr}, {59'd0, e[REG_W+DATA_W-1:DATA_W]});
                check("sb_wdata", {32'd0, reg_wdata}, {32'd0, e[DATA_W-1:0]});
            end
        end
    end

    task automatic push_expected(input logic [ADDR_W-1:0] b, input logic [REG_W-1:0] c,
                                 input logic [REG_W-1:0] d, input int n_words);
        logic [DATA_W-1:0] acc;
        logic [ADDR_W-1:0] a;
        logic [REG_W-1:0]  r;
        acc = 32'd0;
        for (int i = 0; i < int'(c); i++) begin
            a = b + ADDR_W'(i);
            r = d + REG_W'(i);
            acc = acc + mem[a];
            if (i < n_words && r != 5'd0) sb_q.push_back({r, mem[a]});
        end
`ifdef MEM_LOADER_SUM_EN
        if (n_words >= int'(c) && sum_reg != 5'd0) sb_q.push_back({sum_reg, acc});
`endif
    endtask

    task automatic run_load(input logic [ADDR_W-1:0] b, input logic [REG_W-1:0] c,
                            input logic [REG_W-1:0] d, input int exp_lat, input logic exp_err,
                            input int exp_reads, input string nm);
        int lat, rd0, dn0, aq0;
        logic [ADDR_W-1:0] a;
        rd0 = read_cnt;
        dn0 = done_cnt;
        aq0 = addr_q.size();
        if (!exp_err) push_expected(b, c, d, 64);
        @(negedge clock);
        start = 1'b1; base_addr = b; count = c; dest_reg = d;
        @(negedge clock);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 300) begin
            @(negedge clock);
            lat++;
        end
        check({nm, "_latency"}, 64'(lat), 64'(exp_lat));
        check({nm, "_err"}, {63'd0, err}, {63'd0, exp_err});
        check({nm, "_busy_at_done"}, {63'd0, busy}, 64'd0);
        @(negedge clock);
        check({nm, "_done_pulse"}, {63'd0, done}, 64'd0);
        check({nm, "_done_count"}, 64'(done_cnt - dn0), 64'd1);
        check({nm, "_reads"}, 64'(read_cnt - rd0), 64'(exp_reads));
        for (int i = 0; i < exp_reads && aq0 + i < addr_q.size(); i++) begin
            a = b + ADDR_W'(i);
            check({nm, "_mem_addr"}, {57'd0, addr_q[aq0 + i]}, {57'd0, a});
        end
        check({nm, "_sb_drained"}, 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        vec_t tab [7];
        logic [DATA_W-1:0] prior [7];
        int lat, rd0, dn0;
        logic [ADDR_W-1:0] pend_b;

        for (int i = 0; i < 128; i++) mem[i] = 32'h1000 + 32'(i);
        mem[0] = 32'd5; mem[1] = 32'd2; mem[2] = 32'd0;
        mem[3] = 32'd5; mem[4] = 32'd6; mem[5] = 32'd3;
        tab[0] = '{base: 7'd126, cnt: 5'd3,  dest: 5'd10, lat: 7,  err: 1'b0, reads: 3};
        tab[1] = '{base: 7'd0,   cnt: 5'd3,  dest: 5'd30, lat: 1,  err: 1'b1, reads: 0};
        tab[2] = '{base: 7'd0,   cnt: 5'd2,  dest: 5'd0,  lat: 5,  err: 1'b0, reads: 2};
        tab[3] = '{base: 7'd5,   cnt: 5'd0,  dest: 5'd5,  lat: 1,  err: 1'b0, reads: 0};
        tab[4] = '{base: 7'd40,  cnt: 5'd31, dest: 5'd1,  lat: 63, err: 1'b0, reads: 31};
        tab[5] = '{base: 7'd40,  cnt: 5'd31, dest: 5'd2,  lat: 1,  err: 1'b1, reads: 0};
        tab[6] = '{base: 7'd100, cnt: 5'd1,  dest: 5'd31, lat: 3,  err: 1'b0, reads: 1};

        reset_n = 1'b0; start = 1'b0; base_addr = 7'd0; count = 5'd0; dest_reg = 5'd0;
`ifdef MEM_LOADER_SUM_EN
        sum_reg = 5'd31;
`endif
        #12;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        check("rst_mem_read", {63'd0, mem_read}, 64'd0);
        check("rst_reg_write", {63'd0, reg_write}, 64'd0);
        check("rst_mem_addr", {57'd0, mem_addr}, 64'd0);
        check("rst_reg_waddr", {59'd0, reg_waddr}, 64'd0);
        check("rst_reg_wdata", {32'd0, reg_wdata}, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;

        run_load(7'd0, 5'd6, 5'd1, 13 + SUM_EXTRA, 1'b0, 6, "basic6");
        check("basic6_r1", {32'd0, rf[1]}, 64'd5);
        check("basic6_r2", {32'd0, rf[2]}, 64'd2);
        check("basic6_r3", {32'd0, rf[3]}, 64'd0);
        check("basic6_r4", {32'd0, rf[4]}, 64'd5);
        check("basic6_r5", {32'd0, rf[5]}, 64'd6);
        check("basic6_r6", {32'd0, rf[6]}, 64'd3);
`ifdef MEM_LOADER_SUM_EN
        check("basic6_sum_r31", {32'd0, rf[31]}, 64'd21);
`endif

        for (int k = 0; k < 7; k++) begin
            run_load(tab[k].base, tab[k].cnt, tab[k].dest,
                     tab[k].lat + (tab[k].err ? 0 : SUM_EXTRA), tab[k].err, tab[k].reads,
                     $sformatf("vec%0d", k));
        end

        // Abort after the second WRITE: only $1 and $2 take new data.
        for (int i = 3; i <= 6; i++) prior[i] = rf[i];
        dn0 = done_cnt;
        push_expected(7'd6, 5'd6, 5'd1, 2);
        @(negedge clock);
        start = 1'b1; base_addr = 7'd6; count = 5'd6; dest_reg = 5'd1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        @(posedge clock);
        #1 reset_n = 1'b0;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_mem_read", {63'd0, mem_read}, 64'd0);
        repeat (3) @(negedge clock);
        check("abort_no_done", 64'(done_cnt - dn0), 64'd0);
        check("abort_sb_drained", 64'(sb_q.size()), 64'd0);
        check("abort_r1", {32'd0, rf[1]}, {32'd0, mem[6]});
        check("abort_r2", {32'd0, rf[2]}, {32'd0, mem[7]});
        for (int i = 3; i <= 6; i++) check("abort_kept", {32'd0, rf[i]}, {32'd0, prior[i]});

        // Start on the first edge after reset release.
        push_expected(7'd3, 5'd1, 5'd20, 64);
        reset_n = 1'b1;
        start = 1'b1; base_addr = 7'd3; count = 5'd1; dest_reg = 5'd20;
        @(negedge clock);
        start = 1'b0;
        check("rel_mem_read", {63'd0, mem_read}, 64'd1);
        check("rel_mem_addr", {57'd0, mem_addr}, 64'd3);
        check("rel_busy", {63'd0, busy}, 64'd1);
        lat = 1;
        while (!done && lat < 300) begin
            @(negedge clock);
            lat++;
        end
        check("rel_latency", 64'(lat), 64'(3 + SUM_EXTRA));
        @(negedge clock);
        check("rel_sb_drained", 64'(sb_q.size()), 64'd0);

        // A second start while busy must be ignored.
        rd0 = read_cnt;
        dn0 = done_cnt;
        push_expected(7'd20, 5'd3, 5'd10, 64);
        @(negedge clock);
        start = 1'b1; base_addr = 7'd20; count = 5'd3; dest_reg = 5'd10;
        @(negedge clock);
        start = 1'b0;
        lat = 1;
        pend_b = 7'd50;
        while (!done && lat < 300) begin
            @(negedge clock);
            lat++;
            if (lat == 2) begin
                start = 1'b1; base_addr = pend_b; count = 5'd1; dest_reg = 5'd20;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("ign_latency", 64'(lat), 64'(7 + SUM_EXTRA));
        repeat (10) @(negedge clock);
        check("ign_reads", 64'(read_cnt - rd0), 64'd3);
        check("ign_done_count", 64'(done_cnt - dn0), 64'd1);
        check("ign_busy", {63'd0, busy}, 64'd0);
        check("ign_sb_drained", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
